pixel_variance_accum: RTL and testbench

- Downstream consumer of the registered 8-bit pixel-squaring lookup stage.
- Accumulates pixel values and their squares over fixed windows of N = 2^LOG2N valid pixels.
- At the end of each window it emits the mean and the variance, computed as E[x^2] - (E[x])^2.
- Used for local contrast / sharpness statistics in the image pipeline. Accumulation is streaming: no pixel is lost between windows.

---
 rtl/pixel_variance_accum.sv | 121 ++++++++++++
 tb/tb_pixel_variance_accum.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pixel_variance_accum.sv
// pixel_variance_accum: accumulates pixel and pixel^2 over windows of
// 2^LOG2N valid samples and emits mean and variance (E[x^2] - E[x]^2)
// through a 3-stage one-hot calc pipeline.
module pixel_variance_accum #(
   parameter int LOG2N = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              work,
   input  logic [7:0]        pixel,
   input  logic [15:0]       pixel_square,
   output logic [7:0]        mean_out,
   output logic [15:0]       var_out,
   output logic              var_valid,
   output logic [LOG2N-1:0]  sample_cnt
);

   localparam int SW = 8 + LOG2N;
   localparam int QW = 16 + LOG2N;

   logic          work_d;
   logic [7:0]    pixel_d;
   logic [SW-1:0] sum, s_sum, sum_nxt;
   logic [QW-1:0] sumsq, s_sq, sq_nxt;
   logic          win_close;

   // vld_pipe[0]=C1 pending, [1]=C2 pending, [2]=C3 pending
   logic [2:0]    vld_pipe;
   logic [7:0]    mean;
   logic [15:0]   msq;
   logic [15:0]   mean_sq;
   logic [16:0]   var_diff;

   // Window closes on the valid sample that brings the count to N
   assign win_close = work_d & (&sample_cnt);
   assign sum_nxt   = sum + SW'(pixel_d);
   assign sq_nxt    = sumsq + QW'(pixel_square);
   // Extra MSB catches a negative difference for the clamp
   assign var_diff  = {1'b0, msq} - {1'b0, mean_sq};

   // Align pixel/work with the registered square from the squaring stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_d  <= 1'b0;
         pixel_d <= '0;
      end else begin
         work_d  <= work & ~clear;
         pixel_d <= pixel;
      end
   end

   // Streaming accumulation; window close snapshots and restarts with no gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum        <= '0;
         sumsq      <= '0;
         sample_cnt <= '0;
         s_sum      <= '0;
         s_sq       <= '0;
      end else if (clear) begin
         sum        <= '0;
         sumsq      <= '0;
         sample_cnt <= '0;
      end else if (win_close) begin
         s_sum      <= sum_nxt;
         s_sq       <= sq_nxt;
         sum        <= '0;
         sumsq      <= '0;
         sample_cnt <= '0;
      end else if (work_d) begin
         sum        <= sum_nxt;
         sumsq      <= sq_nxt;
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   // One-hot calc stage tracker; clear discards any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else if (clear) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1:0], win_close};
      end
   end

   // C1: divide by N; C2: square the mean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mean    <= '0;
         msq     <= '0;
         mean_sq <= '0;
      end else begin
         if (vld_pipe[0]) begin
            mean <= s_sum[SW-1:LOG2N];
            msq  <= s_sq[QW-1:LOG2N];
         end
         if (vld_pipe[1]) mean_sq <= 16'(mean) * 16'(mean);
      end
   end

   // C3: publish mean/variance with a one-cycle valid pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mean_out  <= '0;
         var_out   <= '0;
         var_valid <= 1'b0;
      end else if (clear) begin
         var_valid <= 1'b0;
      end else begin
         var_valid <= vld_pipe[2];
         if (vld_pipe[2]) begin
            mean_out <= mean;
            var_out  <= var_diff[16] ? 16'd0 : var_diff[15:0];
         end
      end
   end

endmodule

// File: tb/tb_pixel_variance_accum.sv
// Scoreboard bench for pixel_variance_accum: stimulus pushes hand-computed
// window results, a negedge monitor pops and compares on each var_valid.
module tb_pixel_variance_accum;

   localparam int LOG2N = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              work = 1'b0;
   logic [7:0]        pixel = '0;
   logic [15:0]       pixel_square;
   logic [7:0]        mean_out;
   logic [15:0]       var_out;
   logic              var_valid;
   logic [LOG2N-1:0]  sample_cnt;

   typedef struct {
      int m;
      int v;
      int c;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   pixel_variance_accum #(.LOG2N(LOG2N)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .work(work), .pixel(pixel),
      .pixel_square(pixel_square), .mean_out(mean_out), .var_out(var_out),
      .var_valid(var_valid), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   // registered squaring stage model feeding the DUT
   always @(posedge clk) pixel_square <= work ? 16'(pixel) * 16'(pixel) : 16'd0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input bit w, input int p, input bit clr = 1'b0);
      @(negedge clk);
      work  = w;
      pixel = 8'(p);
      clear = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, $urandom_range(255));
   endtask

   // call right after driving the Nth pixel: pulse expected 4 edges after E0
   task automatic expect_win(input int m, input int v);
      q.push_back('{m, v, cyc + 5});
   endtask

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && var_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               mon_e = q.pop_front();
               chk("mean_out", int'(mean_out), mon_e.m);
               chk("var_out", int'(var_out), mon_e.v);
               chk("pulse_cycle", cyc, mon_e.c);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_mean", int'(mean_out), 0);
      chk("rst_var", int'(var_out), 0);
      chk("rst_valid", int'(var_valid), 0);
      chk("rst_cnt", int'(sample_cnt), 0);
      rst_n = 1'b1;
      idle(2);

      // constant window
      for (int i = 0; i < 64; i++) drive(1'b1, 100);
      expect_win(100, 0);
      idle(8);

      // alternating extremes
      for (int i = 0; i < 64; i++) drive(1'b1, (i % 2) ? 255 : 0);
      expect_win(127, 16383);
      idle(8);

      // ramp 0..63 with random gaps of garbage pixels
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(2) == 0) idle($urandom_range(3, 1));
         drive(1'b1, i);
         if (i == 31) begin
            idle(2);
            chk("gap_cnt", int'(sample_cnt), 32);
         end
      end
      expect_win(31, 372);
      idle(8);

      // back-to-back ramp 0..127
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, i);
         if (i == 63)  expect_win(31, 372);
         if (i == 127) expect_win(95, 436);
      end
      idle(8);

      // partial window dropped by clear
      for (int i = 0; i < 30; i++) drive(1'b1, 50);
      drive(1'b0, 0, 1'b1);
      idle(1);
      chk("clear_cnt", int'(sample_cnt), 0);
      for (int i = 0; i < 64; i++) drive(1'b1, 10);
      expect_win(10, 0);
      idle(8);

      // clear while C2 is pending: no pulse, outputs held
      for (int i = 0; i < 64; i++) drive(1'b1, 77);
      idle(2);
      drive(1'b0, 0, 1'b1);
      idle(8);
      chk("c2clr_mean", int'(mean_out), 10);
      chk("c2clr_var", int'(var_out), 0);
      chk("c2clr_q", q.size(), 0);

      // async reset mid-window
      for (int i = 0; i < 20; i++) drive(1'b1, 33);
      @(posedge clk);
      #2 rst_n = 1'b0;
      work = 1'b0;
      #1;
      chk("arst_mean", int'(mean_out), 0);
      chk("arst_var", int'(var_out), 0);
      chk("arst_valid", int'(var_valid), 0);
      chk("arst_cnt", int'(sample_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) drive(1'b1, 200);
      expect_win(200, 0);
      idle(8);

      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
